// File: rtl/reg_writeback.sv
// Register-file write master: two valid/ready source FIFOs, round-robin drain, registered write port.
// Latency: accept edge k -> wb_flag during k+1..k+2; sN_ready drops only when that source's FIFO is full.
module reg_writeback #(
    parameter int LEN_REG  = 32,
    parameter int LEN_ADDR = 5,
    parameter int DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                s0_valid,
    output logic                s0_ready,
    input  logic [LEN_ADDR-1:0] s0_addr,
    input  logic [LEN_REG-1:0]  s0_data,
    input  logic                s1_valid,
    output logic                s1_ready,
    input  logic [LEN_ADDR-1:0] s1_addr,
    input  logic [LEN_REG-1:0]  s1_data,
    output logic                wb_flag,
    output logic [LEN_ADDR-1:0] wb_addr,
    output logic [LEN_REG-1:0]  wb_data,
    input  logic [LEN_ADDR-1:0] chk_rs1,
    input  logic [LEN_ADDR-1:0] chk_rs2,
    output logic                pend_rs1,
    output logic                pend_rs2,
    output logic                idle
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic                in_vld  [2];
    logic [LEN_ADDR-1:0] in_addr [2];
    logic [LEN_REG-1:0]  in_data [2];

    assign in_vld[0]  = s0_valid;
    assign in_vld[1]  = s1_valid;
    assign in_addr[0] = s0_addr;
    assign in_addr[1] = s1_addr;
    assign in_data[0] = s0_data;
    assign in_data[1] = s1_data;

    logic [LEN_ADDR-1:0] addr_q [2][DEPTH];
    logic [LEN_REG-1:0]  data_q [2][DEPTH];
    logic [DEPTH-1:0]    occ_q  [2];
    logic [DEPTH-1:0]    occ_d  [2];
    logic [PTR_W-1:0]    wptr_q [2];
    logic [PTR_W-1:0]    wptr_d [2];
    logic [PTR_W-1:0]    rptr_q [2];
    logic [PTR_W-1:0]    rptr_d [2];
    logic [CNT_W-1:0]    cnt_q  [2];
    logic [CNT_W-1:0]    cnt_d  [2];

    logic                rr_q, rr_d;
    logic                wb_flag_q, wb_flag_d;
    logic [LEN_ADDR-1:0] wb_addr_q, wb_addr_d;
    logic [LEN_REG-1:0]  wb_data_q, wb_data_d;

    logic rdy  [2];
    logic ne   [2];
    logic push [2];
    logic pop  [2];
    logic hit1, hit2;

    // Ready and grant come from registered counts only, so a full FIFO refuses even while popping.
    always_comb begin : flow
        for (int s = 0; s < 2; s++) begin
            rdy[s]  = (cnt_q[s] != CNT_FULL);
            ne[s]   = (cnt_q[s] != '0);
            push[s] = in_vld[s] && rdy[s] && (in_addr[s] != '0);
        end
        pop[0] = ne[0] && (!ne[1] || !rr_q);
        pop[1] = ne[1] && (!ne[0] ||  rr_q);
    end

    always_comb begin : fifo_next
        for (int s = 0; s < 2; s++) begin
            wptr_d[s] = wptr_q[s];
            rptr_d[s] = rptr_q[s];
            occ_d[s]  = occ_q[s];
            cnt_d[s]  = cnt_q[s];
            if (push[s]) begin
                wptr_d[s]            = wptr_q[s] + 1'b1;
                occ_d[s][wptr_q[s]]  = 1'b1;
            end
            if (pop[s]) begin
                rptr_d[s]            = rptr_q[s] + 1'b1;
                occ_d[s][rptr_q[s]]  = 1'b0;
            end
            case ({push[s], pop[s]})
                2'b10:   cnt_d[s] = cnt_q[s] + 1'b1;
                2'b01:   cnt_d[s] = cnt_q[s] - 1'b1;
                default: cnt_d[s] = cnt_q[s];
            endcase
        end
    end

    always_comb begin : arb_next
        rr_d      = rr_q;
        wb_flag_d = pop[0] || pop[1];
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        if (ne[0] && ne[1]) begin
            rr_d = !rr_q;
        end
        if (pop[1]) begin
            wb_addr_d = addr_q[1][rptr_q[1]];
            wb_data_d = data_q[1][rptr_q[1]];
        end else if (pop[0]) begin
            wb_addr_d = addr_q[0][rptr_q[0]];
            wb_data_d = data_q[0][rptr_q[0]];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 0; s < 2; s++) begin
                wptr_q[s] <= '0;
                rptr_q[s] <= '0;
                occ_q[s]  <= '0;
                cnt_q[s]  <= '0;
            end
            rr_q      <= 1'b0;
            wb_flag_q <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                wptr_q[s] <= wptr_d[s];
                rptr_q[s] <= rptr_d[s];
                occ_q[s]  <= occ_d[s];
                cnt_q[s]  <= cnt_d[s];
            end
            rr_q      <= rr_d;
            wb_flag_q <= wb_flag_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
        end
    end

    // Payload storage needs no reset: occupancy bits gate every use of it.
    always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (push[s]) begin
                addr_q[s][wptr_q[s]] <= in_addr[s];
                data_q[s][wptr_q[s]] <= in_data[s];
            end
        end
    end

    always_comb begin : hazard
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (occ_q[s][i] && (addr_q[s][i] == chk_rs1)) hit1 = 1'b1;
                if (occ_q[s][i] && (addr_q[s][i] == chk_rs2)) hit2 = 1'b1;
            end
        end
        if (wb_flag_q && (wb_addr_q == chk_rs1)) hit1 = 1'b1;
        if (wb_flag_q && (wb_addr_q == chk_rs2)) hit2 = 1'b1;
    end

    assign pend_rs1 = (chk_rs1 != '0) && hit1;
    assign pend_rs2 = (chk_rs2 != '0) && hit2;

    assign s0_ready = rdy[0];
    assign s1_ready = rdy[1];
    assign wb_flag  = wb_flag_q;
    assign wb_addr  = wb_addr_q;
    assign wb_data  = wb_data_q;
    assign idle     = (cnt_q[0] == '0) && (cnt_q[1] == '0) && !wb_flag_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: latency, arbitration order, backpressure, addr-0 drop, hazards, async reset.
module tb_reg_writeback;

    logic        clk = 1'b0;
    logic        rstn;
    logic        s0_valid, s0_ready, s1_valid, s1_ready;
    logic [4:0]  s0_addr, s1_addr, wb_addr, chk_rs1, chk_rs2;
    logic [31:0] s0_data, s1_data, wb_data;
    logic        wb_flag, pend_rs1, pend_rs2, idle;

    int n_pass  = 0;
    int n_total = 0;

    reg_writeback #(.LEN_REG(32), .LEN_ADDR(5), .DEPTH(2)) dut (
        .clk(clk), .rstn(rstn),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr), .s0_data(s0_data),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr), .s1_data(s1_data),
        .wb_flag(wb_flag), .wb_addr(wb_addr), .wb_data(wb_data),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .pend_rs1(pend_rs1), .pend_rs2(pend_rs2),
        .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_wb(input string tag, input logic [4:0] a, input logic [31:0] d);
        chk({tag, ".flag"}, 64'(wb_flag), 64'd1);
        chk({tag, ".addr"}, 64'(wb_addr), 64'(a));
        chk({tag, ".data"}, 64'(wb_data), 64'(d));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic [4:0] a, input logic [31:0] d);
        s0_valid = v; s0_addr = a; s0_data = d;
    endtask

    task automatic drive1(input logic v, input logic [4:0] a, input logic [31:0] d);
        s1_valid = v; s1_addr = a; s1_data = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with s0 already offering addr 5
        rstn = 1'b0;
        drive0(1'b1, 5'd5, 32'hDEADBEEF);
        drive1(1'b0, 5'd0, 32'h0);
        chk_rs1 = 5'd0; chk_rs2 = 5'd0;
        #2;
        chk("rst.s0_ready", 64'(s0_ready), 64'd1);
        chk("rst.s1_ready", 64'(s1_ready), 64'd1);
        chk("rst.wb_flag",  64'(wb_flag),  64'd0);
        chk("rst.wb_addr",  64'(wb_addr),  64'd0);
        chk("rst.wb_data",  64'(wb_data),  64'd0);
        chk("rst.idle",     64'(idle),     64'd1);
        chk("rst.pend1",    64'(pend_rs1), 64'd0);
        chk("rst.pend2",    64'(pend_rs2), 64'd0);
        @(posedge clk);
        #3 rstn = 1'b1;

        // Latency: accept at edge 1, write visible after edge 2, idle after edge 3
        tick;
        s0_valid = 1'b0;
        chk("lat.e1.flag", 64'(wb_flag), 64'd0);
        chk("lat.e1.idle", 64'(idle), 64'd0);
        tick;
        chk_wb("lat.e2", 5'd5, 32'hDEADBEEF);
        tick;
        chk("lat.e3.flag", 64'(wb_flag), 64'd0);
        chk("lat.e3.idle", 64'(idle), 64'd1);
        chk("lat.e3.hold", 64'(wb_addr), 64'd5);

        // Both sources streaming; pointer starts at source 0
        drive0(1'b1, 5'd1, 32'h101);
        drive1(1'b1, 5'd9, 32'h109);
        tick;
        chk("rr.A.flag", 64'(wb_flag), 64'd0);
        drive0(1'b1, 5'd2, 32'h102);
        drive1(1'b1, 5'd10, 32'h110);
        tick;
        chk_wb("rr.B", 5'd1, 32'h101);
        chk("rr.B.s1_ready", 64'(s1_ready), 64'd0);
        chk("rr.B.s0_ready", 64'(s0_ready), 64'd1);
        drive0(1'b1, 5'd3, 32'h103);
        drive1(1'b1, 5'd11, 32'h111);
        tick;
        chk_wb("rr.C", 5'd9, 32'h109);
        chk("rr.C.s0_ready", 64'(s0_ready), 64'd0);
        chk("rr.C.s1_ready", 64'(s1_ready), 64'd1);
        s0_valid = 1'b0;
        tick;
        chk_wb("rr.D", 5'd2, 32'h102);
        s1_valid = 1'b0;
        tick;
        chk_wb("rr.E", 5'd10, 32'h110);
        tick;
        chk_wb("rr.F", 5'd3, 32'h103);
        tick;
        chk_wb("rr.G", 5'd11, 32'h111);
        tick;
        chk("rr.H.flag", 64'(wb_flag), 64'd0);
        chk("rr.H.idle", 64'(idle), 64'd1);

        // Saturation: pointer now at source 1; full FIFOs refuse even on their pop cycle
        drive0(1'b1, 5'd16, 32'h216);
        drive1(1'b1, 5'd20, 32'h220);
        tick;
        chk("sat.E1.flag", 64'(wb_flag), 64'd0);
        drive0(1'b1, 5'd17, 32'h217);
        drive1(1'b1, 5'd21, 32'h221);
        tick;
        chk_wb("sat.E2", 5'd20, 32'h220);
        chk("sat.E2.s0_ready", 64'(s0_ready), 64'd0);
        chk("sat.E2.s1_ready", 64'(s1_ready), 64'd1);
        drive0(1'b1, 5'd18, 32'h218);
        drive1(1'b1, 5'd22, 32'h222);
        tick;
        chk_wb("sat.E3", 5'd16, 32'h216);
        chk("sat.E3.s0_ready", 64'(s0_ready), 64'd1);
        chk("sat.E3.s1_ready", 64'(s1_ready), 64'd0);
        drive1(1'b1, 5'd23, 32'h223);
        tick;
        chk_wb("sat.E4", 5'd21, 32'h221);
        chk("sat.E4.s0_ready", 64'(s0_ready), 64'd0);
        chk("sat.E4.s1_ready", 64'(s1_ready), 64'd1);
        drive0(1'b1, 5'd19, 32'h219);
        tick;
        chk_wb("sat.E5", 5'd17, 32'h217);
        chk("sat.E5.s0_ready", 64'(s0_ready), 64'd1);
        chk("sat.E5.s1_ready", 64'(s1_ready), 64'd0);
        s1_valid = 1'b0;
        tick;
        chk_wb("sat.E6", 5'd22, 32'h222);
        s0_valid = 1'b0;
        tick;
        chk_wb("sat.E7", 5'd18, 32'h218);
        tick;
        chk_wb("sat.E8", 5'd23, 32'h223);
        tick;
        chk_wb("sat.E9", 5'd19, 32'h219);
        tick;
        chk("sat.E10.flag", 64'(wb_flag), 64'd0);
        chk("sat.E10.idle", 64'(idle), 64'd1);

        // Address zero: handshake completes but nothing is written or flagged
        drive1(1'b1, 5'd0, 32'h1234);
        chk_rs1 = 5'd0;
        #1;
        chk("z.s1_ready", 64'(s1_ready), 64'd1);
        tick;
        s1_valid = 1'b0;
        chk("z.e1.flag",  64'(wb_flag),  64'd0);
        chk("z.e1.idle",  64'(idle),     64'd1);
        chk("z.e1.pend1", 64'(pend_rs1), 64'd0);
        tick;
        chk("z.e2.flag",  64'(wb_flag),  64'd0);
        chk("z.e2.idle",  64'(idle),     64'd1);
        chk("z.e2.pend1", 64'(pend_rs1), 64'd0);

        // Hazard flags follow addr 7 from FIFO through the write cycle
        drive0(1'b1, 5'd7, 32'h77);
        chk_rs1 = 5'd7; chk_rs2 = 5'd8;
        #1;
        chk("hz.pre.pend1", 64'(pend_rs1), 64'd0);
        tick;
        s0_valid = 1'b0;
        chk("hz.q.pend1", 64'(pend_rs1), 64'd1);
        chk("hz.q.pend2", 64'(pend_rs2), 64'd0);
        chk_rs2 = 5'd7;
        #1;
        chk("hz.q.pend2_7", 64'(pend_rs2), 64'd1);
        chk_rs2 = 5'd8;
        tick;
        chk_wb("hz.wb", 5'd7, 32'h77);
        chk("hz.wb.pend1", 64'(pend_rs1), 64'd1);
        chk("hz.wb.pend2", 64'(pend_rs2), 64'd0);
        tick;
        chk("hz.done.pend1", 64'(pend_rs1), 64'd0);
        chk("hz.done.pend2", 64'(pend_rs2), 64'd0);

        // Fill both FIFOs, then async reset mid-cycle discards everything
        drive0(1'b1, 5'd12, 32'h312);
        drive1(1'b1, 5'd24, 32'h324);
        chk_rs1 = 5'd13;
        tick;
        drive0(1'b1, 5'd13, 32'h313);
        drive1(1'b1, 5'd25, 32'h325);
        tick;
        drive0(1'b0, 5'd0, 32'h0);
        drive1(1'b0, 5'd0, 32'h0);
        chk_wb("ar.pre", 5'd12, 32'h312);
        chk("ar.pre.pend1", 64'(pend_rs1), 64'd1);
        #1 rstn = 1'b0;
        #1;
        chk("ar.flag",     64'(wb_flag),  64'd0);
        chk("ar.addr",     64'(wb_addr),  64'd0);
        chk("ar.s0_ready", 64'(s0_ready), 64'd1);
        chk("ar.s1_ready", 64'(s1_ready), 64'd1);
        chk("ar.idle",     64'(idle),     64'd1);
        chk("ar.pend1",    64'(pend_rs1), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("ar.post.flag", 64'(wb_flag), 64'd0);
        end
        chk("ar.post.idle", 64'(idle), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
